// File: rtl/dct_pkg.sv
// Shared types, constants and helpers for the 8x8 2D-DCT engine.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro DCT_ROUND_EN selects round-half-up before each shift.
package dct_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 64;
  localparam int FRAC   = 6;
  localparam int NWORDS = 1 << ADDR_W;

  // 12-bit signed intermediate used between and after the two 1D passes
  typedef logic signed [11:0] s12_t;

`ifdef DCT_ROUND_EN
  localparam int RND  = 1 << (FRAC - 1);
  localparam int RND3 = 4;
`else
  localparam int RND  = 0;
  localparam int RND3 = 0;
`endif

  // c[k][n] = round(64*a(k)*cos((2n+1)k*pi/16)), a(0)=1/(2*sqrt2), a(k>0)=1/2
  localparam int C_TAB [8][8] = '{
    '{ 23,  23,  23,  23,  23,  23,  23,  23},
    '{ 31,  27,  18,   6,  -6, -18, -27, -31},
    '{ 30,  12, -12, -30, -30, -12,  12,  30},
    '{ 27,  -6, -31, -18,  18,  31,   6, -27},
    '{ 23, -23, -23,  23,  23, -23, -23,  23},
    '{ 18, -31,   6,  27, -27,  -6,  31, -18},
    '{ 12, -30,  30, -12, -12,  30, -30,  12},
    '{  6, -18,  27, -31,  31, -27,  18,  -6}
  };

  // clamp a signed value to the 8-bit two's complement range
  function automatic logic [7:0] sat8(input int v);
    if (v > 127)
      return 8'h7f;
    else if (v < -128)
      return 8'h80;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/dct8_1d.sv
// 8-point 1D DCT: constant 8x8 matrix multiply, rounding offset, arithmetic shift by FRAC.
// Latency: 1 cycle (single output register stage).
// Backpressure: none; accepts one vector per cycle whenever in_vld is high.
module dct8_1d
  import dct_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  s12_t x [8],
  output logic out_vld,
  output s12_t y [8]
);

  int   acc   [8];
  s12_t y_nxt [8];

  // multiply-accumulate per output coefficient, then round/shift down to 12 bits
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      acc[k] = RND;
      for (int n = 0; n < 8; n++) begin
        acc[k] = acc[k] + C_TAB[k][n] * int'(x[n]);
      end
      acc[k]   = acc[k] >>> FRAC;
      y_nxt[k] = acc[k][11:0];
    end
  end

  // valid bit follows the data through the register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_vld <= 1'b0;
    else     out_vld <= in_vld;
  end

  // result register; data needs no reset because out_vld qualifies it
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      y[k] <= y_nxt[k];
    end
  end

endmodule

// File: rtl/sram_wrap.sv
// Single-port 32768x64 SRAM model plus the wrapper instantiated for MEM_IN and MEM_OUT.
// Latency: read data 1 cycle after cs with we low; write lands on the clock edge.
// Backpressure: none; one access per cycle.
module SRAM32768x64
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] Mem [0:NWORDS-1];

  // synchronous write, or synchronous read into q
  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) Mem[addr] <= d;
      else    q         <= Mem[addr];
    end
  end

endmodule

module sram_wrap
  import dct_pkg::*;
(
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  SRAM32768x64 SRAM_syn (
    .clk  (clk),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .d    (d),
    .q    (q)
  );

endmodule

// File: rtl/top_mem_dct.sv
// Frame-level 2D-DCT: sweeps MEM_IN, row DCT, ping-pong transpose, column DCT, saturate, MEM_OUT.
// Latency: 13 cycles from read address to the matching MEM_OUT write, 1 word/cycle sustained.
// Backpressure: none; free-running stream, stops after the last write (DCT_ROUND_EN selects rounding).
module top_mem_dct
  import dct_pkg::*;
(
  input  logic clk,
  input  logic reset
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // read side
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_en;
  logic              in_vld;
  logic [DATA_W-1:0] in_q;

  // row pass
  s12_t x1 [8];
  s12_t y1 [8];
  logic s1_vld;

  // transpose banks [bank][row][col]
  s12_t tbank [2][8][8];
  logic [2:0] wr_row;
  logic       wr_bank;
  logic       rd_bank;
  logic       col_act;
  logic [2:0] col;

  // column pass
  s12_t x2 [8];
  s12_t z2 [8];
  logic s2_vld;

  // write side
  logic [DATA_W-1:0] out_word;
  logic [DATA_W-1:0] out_dat;
  logic              out_we;
  logic [ADDR_W-1:0] wr_addr;
  logic              done;
  logic [DATA_W-1:0] mem_out_q_unused;

  assign rd_en = !rd_done;

  sram_wrap MEM_IN (
    .clk  (clk),
    .cs   (rd_en),
    .we   (1'b0),
    .addr (rd_addr),
    .d    ({DATA_W{1'b0}}),
    .q    (in_q)
  );

  // one read per cycle over the whole frame, then stop for good
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      rd_done <= 1'b0;
      in_vld  <= 1'b0;
    end else begin
      in_vld <= rd_en;
      if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        if (rd_addr == LAST_ADDR) rd_done <= 1'b1;
      end
    end
  end

  // unpack a row and level-shift the unsigned pixels to signed
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      x1[n] = $signed({4'b0000, in_q[DATA_W-1-8*n -: 8]}) - 12'sd128;
    end
  end

  dct8_1d u_row (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (in_vld),
    .x       (x1),
    .out_vld (s1_vld),
    .y       (y1)
  );

  // store each row-DCT result into the bank currently being filled
  always_ff @(posedge clk) begin
    if (s1_vld) begin
      for (int k = 0; k < 8; k++) begin
        tbank[wr_bank][wr_row][k] <= y1[k];
      end
    end
  end

  // fill/drain sequencing: a full bank flips over and is drained one column per cycle;
  // filling and draining both take 8 cycles so the next block's last row restarts the drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      col_act <= 1'b0;
      col     <= '0;
    end else begin
      if (col_act) begin
        col <= col + 1'b1;
        if (col == 3'd7) col_act <= 1'b0;
      end
      if (s1_vld) begin
        wr_row <= wr_row + 1'b1;
        if (wr_row == 3'd7) begin
          wr_bank <= ~wr_bank;
          rd_bank <= wr_bank;
          col_act <= 1'b1;
          col     <= '0;
        end
      end
    end
  end

  // column select out of the drained bank
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      x2[r] = tbank[rd_bank][r][col];
    end
  end

  dct8_1d u_col (
    .clk     (clk),
    .rst     (reset),
    .in_vld  (col_act),
    .x       (x2),
    .out_vld (s2_vld),
    .y       (z2)
  );

  // final /8 with optional rounding, saturate, pack u=0 into the top byte
  always_comb begin
    out_word = '0;
    for (int u = 0; u < 8; u++) begin
      out_word[DATA_W-1-8*u -: 8] = sat8((int'(z2[u]) + RND3) >>> 3);
    end
  end

  // write enable and address counter; done latches after the final word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_we  <= 1'b0;
      wr_addr <= '0;
      done    <= 1'b0;
    end else begin
      out_we <= s2_vld && !done;
      if (out_we) begin
        wr_addr <= wr_addr + 1'b1;
        if (wr_addr == LAST_ADDR) done <= 1'b1;
      end
    end
  end

  // write data register, qualified by out_we
  always_ff @(posedge clk) begin
    out_dat <= out_word;
  end

  sram_wrap MEM_OUT (
    .clk  (clk),
    .cs   (out_we),
    .we   (out_we),
    .addr (wr_addr),
    .d    (out_dat),
    .q    (mem_out_q_unused)
  );

endmodule

// File: tb/tb_top_mem_dct.sv
// Frame-level bench for top_mem_dct: mixed constant/random blocks, mid-frame reset, full compare.
// Latency: checks first-write latency, gap-free streaming and the completion budget.
// Backpressure: none in the design; every wait is bounded by a cycle budget.
module tb_top_mem_dct;

  localparam int NW = 32768;
  localparam int NB = 4096;
  localparam real PI = 3.14159265358979;
`ifdef DCT_ROUND_EN
  localparam int M_RND  = 32;
  localparam int M_RND3 = 4;
`else
  localparam int M_RND  = 0;
  localparam int M_RND3 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  top_mem_dct dut (
    .clk   (clk),
    .reset (reset)
  );

  int n_chk = 0;
  int n_err = 0;

  int ctab [8][8];
  logic [63:0] img  [NW];
  logic [63:0] expw [NW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // block kinds: 0=0x88, 1=0x00, 2=0xFF, 3=0x80, 4=random (last block always random)
  function automatic int btype(input int b);
    if (b == NB - 1) return 4;
    return b % 5;
  endfunction

  function automatic logic [63:0] hand_word(input int t, input int v);
    logic [63:0] w;
    w = 64'h0;
    if (v == 0) begin
      case (t)
        0: w = 64'h0800_0000_0000_0000;
        1: w = 64'h8000_0000_0000_0000;
        2: w = 64'h7F00_0000_0000_0000;
        default: w = 64'h0;
      endcase
    end
    return w;
  endfunction

  task automatic build_model;
    int x [8][8];
    int y [8][8];
    int acc, z, f;
    logic [7:0] p;
    logic [63:0] w;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        real a;
        a = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
        ctab[k][n] = int'($floor(64.0 * a * $cos(real'((2 * n + 1) * k) * PI / 16.0) + 0.5));
      end
    end
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int n = 0; n < 8; n++) begin
          w = img[8 * b + r];
          p = w[63 - 8 * n -: 8];
          x[r][n] = int'(p) - 128;
        end
        for (int k = 0; k < 8; k++) begin
          acc = M_RND;
          for (int n = 0; n < 8; n++) acc += ctab[k][n] * x[r][n];
          y[r][k] = acc >>> 6;
        end
      end
      for (int k = 0; k < 8; k++) begin
        w = 64'h0;
        for (int u = 0; u < 8; u++) begin
          acc = M_RND;
          for (int r = 0; r < 8; r++) acc += ctab[u][r] * y[r][k];
          z = acc >>> 6;
          f = (z + M_RND3) >>> 3;
          if (f > 127) f = 127;
          if (f < -128) f = -128;
          w[63 - 8 * u -: 8] = f[7:0];
        end
        expw[8 * b + k] = w;
      end
    end
  endtask

  initial begin
    int cyc, first, writes, done_cyc, extra;
    int bad [5];
    logic [63:0] got;

    // image: constant blocks by kind, random words for kind 4
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < 8; r++) begin
        case (btype(b))
          0: img[8 * b + r] = {8{8'h88}};
          1: img[8 * b + r] = {8{8'h00}};
          2: img[8 * b + r] = {8{8'hFF}};
          3: img[8 * b + r] = {8{8'h80}};
          default: img[8 * b + r] = {$urandom, $urandom};
        endcase
      end
    end
    for (int a = 0; a < NW; a++) begin
      dut.MEM_IN.SRAM_syn.Mem[a]  <= img[a];
      dut.MEM_OUT.SRAM_syn.Mem[a] <= 64'hA5A5_5A5A_DEAD_BEEF;
    end
    build_model();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr", 64'(dut.rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(dut.wr_addr), 64'd0);
    chk("rst_out_we",  64'(dut.out_we),  64'd0);
    chk("rst_done",    64'(dut.done),    64'd0);
    chk("rst_in_vld",  64'(dut.in_vld),  64'd0);
    reset = 1'b0;

    // partial run, then abort mid-frame
    repeat (5000) @(posedge clk);
    @(negedge clk);
    chk("mid_not_done", 64'(dut.done), 64'd0);
    chk("mid_writing",  64'(dut.wr_addr != 0), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_out_we",  64'(dut.out_we),  64'd0);
    chk("abort_rd_addr", 64'(dut.rd_addr), 64'd0);
    chk("abort_wr_addr", 64'(dut.wr_addr), 64'd0);
    chk("abort_s1_vld",  64'(dut.s1_vld),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // full run from the restart
    cyc = 0;
    first = -1;
    writes = 0;
    while (!dut.done && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dut.out_we) begin
        writes++;
        if (first < 0) first = cyc;
      end
    end
    done_cyc = cyc;
    chk("done_reached",   64'(dut.done), 64'd1);
    chk("first_lat_ok",   64'(first > 0 && first <= 16), 64'd1);
    chk("write_count",    64'(writes), 64'd32768);
    chk("stream_no_gaps", 64'(done_cyc - first), 64'd32768);
    chk("done_budget",    64'(done_cyc <= 32800), 64'd1);

    // quiet after done
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (dut.out_we) extra++;
    end
    chk("no_write_after_done", 64'(extra), 64'd0);
    chk("done_sticky", 64'(dut.done), 64'd1);

    // spot words against hand values
    chk("w0_blk88_dc",  dut.MEM_OUT.SRAM_syn.Mem[0],  64'h0800_0000_0000_0000);
    chk("w1_blk88_ac",  dut.MEM_OUT.SRAM_syn.Mem[1],  64'h0);
    chk("w8_blk00_dc",  dut.MEM_OUT.SRAM_syn.Mem[8],  64'h8000_0000_0000_0000);
    chk("w16_blkff_dc", dut.MEM_OUT.SRAM_syn.Mem[16], 64'h7F00_0000_0000_0000);
    chk("w24_blk80",    dut.MEM_OUT.SRAM_syn.Mem[24], 64'h0);
    chk("w_last_rand",  dut.MEM_OUT.SRAM_syn.Mem[NW - 1], expw[NW - 1]);

    // whole-frame sweep: constant kinds vs hand values, random kind vs model
    for (int t = 0; t < 5; t++) bad[t] = 0;
    for (int wi = 0; wi < NW; wi++) begin
      int t;
      t = btype(wi / 8);
      got = dut.MEM_OUT.SRAM_syn.Mem[wi];
      if (t == 4) begin
        if (got !== expw[wi]) bad[t]++;
      end else begin
        if (got !== hand_word(t, wi % 8)) bad[t]++;
      end
    end
    chk("bad_words_const88", 64'(bad[0]), 64'd0);
    chk("bad_words_const00", 64'(bad[1]), 64'd0);
    chk("bad_words_constff", 64'(bad[2]), 64'd0);
    chk("bad_words_const80", 64'(bad[3]), 64'd0);
    chk("bad_words_random",  64'(bad[4]), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
